trencadis_burst_controller: RTL
===============================

TRENCADIS_BURST_CONTROLLER -- requirements
Module: trencadis_burst_controller

Interface
REQ-001 SHALL have parameter SIZE, default 8, giving the period register width.
REQ-002 SHALL have parameter BURST_W, default 8, giving the burst-length and tick-count width.
REQ-003 SHALL have parameter PEND_W, default 4, giving the pending-event counter width.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start_i  input  1  start request, sampled only in IDLE.
REQ-007 SHALL have port stop_i  input  1  abort request, sampled in RUN.
REQ-008 SHALL have port mode_i  input  1  0 = BURST (finite), 1 = CONTINUOUS; latched on start.
REQ-009 SHALL have port period_i  input  SIZE  tick spacing minus one; latched on start.
REQ-010 SHALL have port burst_len_i  input  BURST_W  ticks per burst; latched on start.
REQ-011 SHALL have port evt_ready_i  input  1  consumer accepts one event.
REQ-012 SHALL have port evt_valid_o  output  1  high when at least one event is pending.
REQ-013 SHALL have port tick_o  output  1  one-cycle tick strobe.
REQ-014 SHALL have port busy_o  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port done_o  output  1  one-cycle strobe on return to IDLE.
REQ-016 SHALL have port err_o  output  1  one-cycle strobe on a rejected start.
REQ-017 SHALL have port overflow_o  output  1  sticky flag for a tick lost while pending was full.
REQ-018 SHALL have port tick_count_o  output  BURST_W  ticks issued since the last accepted start.

Function
REQ-019 FSM SHALL use states IDLE, RUN, DRAIN; transitions: IDLE->RUN on accepted start; RUN->DRAIN on burst complete or stop_i; DRAIN->IDLE when pending == 0.
REQ-020 In IDLE, start_i with period_i == 0, or with mode_i == BURST and burst_len_i == 0, SHALL be rejected: err_o pulses the next cycle and the state stays IDLE.
REQ-021 An accepted start SHALL latch mode, period and burst_len, clear the cycle counter, tick_count_o and overflow_o, and enter RUN.
REQ-022 start_i outside IDLE and stop_i outside RUN SHALL be ignored.
REQ-023 In RUN, the cycle counter SHALL increment each cycle and wrap to 0 at the edge where it equals the latched period; that edge SHALL register tick_o = 1 for exactly one cycle.
REQ-024 The first tick_o SHALL be high period+1 cycles after the start-sampling edge, and each later tick period+1 cycles after the previous one.
REQ-025 Each tick SHALL increment tick_count_o.
REQ-026 In BURST mode, the tick that makes tick_count_o equal burst_len SHALL be the last tick, and the FSM SHALL enter DRAIN on that edge.
REQ-027 stop_i SHALL have priority over a coincident tick: that tick is suppressed, the counter is cleared, and the FSM enters DRAIN.
REQ-028 The pending counter SHALL do +1 on tick, -1 on evt_valid_o && evt_ready_i, and stay unchanged when both occur in the same cycle.
REQ-029 A tick while pending == 2^PEND_W-1 with no accept SHALL leave pending saturated and set overflow_o.
REQ-030 evt_valid_o SHALL be combinational (pending != 0); evt_ready_i while pending == 0 SHALL have no effect.
REQ-031 In DRAIN, the edge at which pending reaches or is found at 0 SHALL move the FSM to IDLE, and done_o SHALL be high for the following cycle.
REQ-032 The period arithmetic SHALL be unsigned SIZE-bit, so period 2^SIZE-1 gives 2^SIZE cycles between ticks.

Reset
REQ-033 Asserting rst_i at any time, including mid-burst, SHALL immediately force IDLE and drive all outputs, counters and latched configuration to 0.
REQ-034 After rst_i deasserts, the first start_i SHALL be sampled on the next rising edge.

Structure
REQ-035 Package trencadis_burst_pkg SHALL hold the state enum (IDLE/RUN/DRAIN) and the mode enum (BURST/CONTINUOUS).
REQ-036 The block SHALL keep its cycle counter internal and SHALL NOT instantiate trencadis_pulse_generator, since that block lacks a synchronous clear and start alignment; no sub-module is required.

Verification
REQ-037 Burst: period=4, burst_len=3, mode=BURST, evt_ready_i=1 -> tick_o at cycles 5, 10, 15 after start; done_o one cycle after the third event drains; tick_count_o=3.
REQ-038 Rejected start: period=0 -> err_o pulse only, busy_o stays 0; then burst_len=0 in BURST mode -> err_o pulse only, busy_o stays 0.
REQ-039 Backpressure: PEND_W=4, period=1, CONTINUOUS, evt_ready_i=0 for 40 cycles -> pending saturates at 15 and overflow_o=1; then evt_ready_i=1 plus stop -> exactly 15 events accepted, then done_o.
REQ-040 Stop/tick collision: period=3, CONTINUOUS, stop_i asserted on the edge of the 2nd tick -> 2nd tick absent, tick_count_o=1, state DRAIN, then IDLE.
REQ-041 Reset mid-burst: period=2^SIZE-1, burst_len=5, rst_i asserted after 300 cycles -> all outputs 0 immediately; a fresh start after release produces its first tick 256 cycles after the start-sampling edge.
REQ-042 Simultaneous tick and accept with pending=2 -> pending stays 2 and evt_valid_o stays 1.

Source files
------------

// File: rtl/trencadis_burst_pkg.sv
// Shared types for the trencadis burst controller: FSM state and run mode.
package trencadis_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef enum logic {
    BURST      = 1'b0,
    CONTINUOUS = 1'b1
  } mode_e;

endpackage

// File: rtl/trencadis_burst_controller.sv
// Periodic tick generator with finite/continuous bursts and a saturating
// pending-event counter drained through a valid/ready event port.
module trencadis_burst_controller
  import trencadis_burst_pkg::*;
#(
  parameter int SIZE    = 8,
  parameter int BURST_W = 8,
  parameter int PEND_W  = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               mode_i,
  input  logic [SIZE-1:0]    period_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic               evt_ready_i,
  output logic               evt_valid_o,
  output logic               tick_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic               overflow_o,
  output logic [BURST_W-1:0] tick_count_o,
  output logic [1:0]         state_o
);

  // Event handshake: an event transfers on a rising edge where evt_valid_o
  // and evt_ready_i are both high; evt_valid_o depends only on pending state.
  localparam logic [SIZE-1:0]    CNT_ONE  = {{(SIZE-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] TC_ONE   = {{(BURST_W-1){1'b0}}, 1'b1};
  localparam logic [PEND_W-1:0]  PEND_ONE = {{(PEND_W-1){1'b0}}, 1'b1};
  localparam logic [PEND_W-1:0]  PEND_MAX = {PEND_W{1'b1}};

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [SIZE-1:0]    period_q, period_d;
  logic [BURST_W-1:0] blen_q, blen_d;
  logic [SIZE-1:0]    cnt_q, cnt_d;
  logic [BURST_W-1:0] tc_q, tc_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic               ovf_q, ovf_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               accept;
  logic               tick_fire;
  logic [BURST_W-1:0] tc_next;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    period_d  = period_q;
    blen_d    = blen_q;
    cnt_d     = cnt_q;
    tc_d      = tc_q;
    pend_d    = pend_q;
    ovf_d     = ovf_q;
    tick_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    tick_fire = 1'b0;
    accept    = (pend_q != '0) && evt_ready_i;
    tc_next   = tc_q + TC_ONE;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if ((period_i == '0) || ((mode_i == BURST) && (burst_len_i == '0))) begin
            err_d = 1'b1;
          end else begin
            mode_d   = mode_e'(mode_i);
            period_d = period_i;
            blen_d   = burst_len_i;
            cnt_d    = '0;
            tc_d     = '0;
            ovf_d    = 1'b0;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        // An abort wins over a tick landing on the same edge.
        if (stop_i) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else if (cnt_q == period_q) begin
          cnt_d     = '0;
          tick_fire = 1'b1;
          tc_d      = tc_next;
          if ((mode_q == BURST) && (tc_next == blen_q)) begin
            state_d = DRAIN;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DRAIN: ;
      default: state_d = IDLE;
    endcase

    if (tick_fire && !accept) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_ONE;
      end
    end else if (!tick_fire && accept) begin
      pend_d = pend_q - PEND_ONE;
    end
    tick_d = tick_fire;

    if ((state_q == DRAIN) && (pend_d == '0)) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mode_q   <= BURST;
      period_q <= '0;
      blen_q   <= '0;
      cnt_q    <= '0;
      tc_q     <= '0;
      pend_q   <= '0;
      ovf_q    <= 1'b0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      blen_q   <= blen_d;
      cnt_q    <= cnt_d;
      tc_q     <= tc_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign evt_valid_o  = (pend_q != '0);
  assign tick_o       = tick_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign overflow_o   = ovf_q;
  assign tick_count_o = tc_q;
  assign state_o      = state_q;

endmodule
